// File: rtl/rect_ctl.sv
// Frame-synchronous position controller for the rectangle sprite: it follows the mouse while idle,
// and after a left click it falls under gravity with damped bounces off a floor line.
module rect_ctl #(
  parameter int unsigned FLOOR_Y = 536,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned VMAX    = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        falling
);

  localparam int unsigned PW = 12;
  localparam int unsigned VW = 8;
  localparam int unsigned SW = PW + 1;

  typedef enum logic [1:0] {HOLD, FALL, RISE, REST} state_t;

  state_t        state;
  logic [VW-1:0] vel;
  logic          vblnk_d;

  logic          tick;
  logic [VW:0]   v_inc;
  logic [VW-1:0] v_sat;
  logic [VW-1:0] v_half;
  logic [SW-1:0] y_sum;
  logic          hit;
  logic [PW-1:0] y_up;
  logic [VW-1:0] vel_dn;
  logic [PW-1:0] y_clamp;

  // Per-frame arithmetic; the sum is one bit wider than ypos so it cannot wrap.
  always_comb begin
    tick    = vblnk & ~vblnk_d;
    v_inc   = (VW+1)'(vel) + (VW+1)'(GRAVITY);
    v_sat   = (v_inc > (VW+1)'(VMAX)) ? VW'(VMAX) : VW'(v_inc);
    v_half  = v_sat >> 1;
    y_sum   = SW'(ypos) + SW'(v_sat);
    hit     = (y_sum >= SW'(FLOOR_Y));
    y_up    = (ypos >= PW'(vel)) ? (ypos - PW'(vel)) : '0;
    vel_dn  = (vel >= VW'(GRAVITY)) ? (vel - VW'(GRAVITY)) : '0;
    y_clamp = (mouse_ypos > PW'(FLOOR_Y)) ? PW'(FLOOR_Y) : mouse_ypos;
  end

  // All state and outputs advance only on the rising edge of vblnk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HOLD;
      vel     <= '0;
      xpos    <= '0;
      ypos    <= '0;
      falling <= 1'b0;
      vblnk_d <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      if (tick) begin
        case (state)
          HOLD: begin
            xpos <= mouse_xpos;
            ypos <= y_clamp;
            if (mouse_left) begin
              vel     <= '0;
              state   <= FALL;
              falling <= 1'b1;
            end else begin
              falling <= 1'b0;
            end
          end
          FALL: begin
            if (hit) begin
              ypos <= PW'(FLOOR_Y);
              vel  <= v_half;
              if (v_half == '0) begin
                state   <= REST;
                falling <= 1'b0;
              end else begin
                state   <= RISE;
                falling <= 1'b1;
              end
            end else begin
              ypos    <= PW'(y_sum);
              vel     <= v_sat;
              falling <= 1'b1;
            end
          end
          RISE: begin
            ypos    <= y_up;
            vel     <= vel_dn;
            falling <= 1'b1;
            if (vel_dn == '0) state <= FALL;
          end
          REST: begin
            ypos <= PW'(FLOOR_Y);
            if (!mouse_left) state <= HOLD;
            falling <= 1'b0;
          end
          default: begin
            state   <= HOLD;
            falling <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
